// File: rtl/cordic_abs_if.sv
// Sample/result bundle for the CORDIC absolute-value unit.
// The master drives operands and the slave returns the registered magnitude and flags.
interface cordic_abs_if #(
  parameter int WORD_WIDTH = 16
);
  logic                  in_valid;
  logic [WORD_WIDTH-1:0] ans;
  logic                  out_valid;
  logic [WORD_WIDTH-1:0] abs_ans;
  logic                  neg;
  logic                  ovf;

  modport master (
    output in_valid,
    output ans,
    input  out_valid,
    input  abs_ans,
    input  neg,
    input  ovf
  );

  modport slave (
    input  in_valid,
    input  ans,
    output out_valid,
    output abs_ans,
    output neg,
    output ovf
  );
endinterface

// File: rtl/cordic_abs.sv
// Registered two's-complement absolute value with sign and overflow flags, one-cycle latency.
// Optional macro CORDIC_ABS_SAT_EN saturates the most-negative input to the most-positive value.
module cordic_abs #(
  parameter int WORD_WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  cordic_abs_if.slave  bus
);

  localparam logic [WORD_WIDTH-1:0] MOST_NEG = {1'b1, {(WORD_WIDTH-1){1'b0}}};
  localparam logic [WORD_WIDTH-1:0] MOST_POS = {1'b0, {(WORD_WIDTH-1){1'b1}}};
  localparam logic [WORD_WIDTH-1:0] ONE      = {{(WORD_WIDTH-1){1'b0}}, 1'b1};

  logic                  valid_q, valid_d;
  logic [WORD_WIDTH-1:0] abs_q, abs_d;
  logic                  neg_q, neg_d;
  logic                  ovf_q, ovf_d;

  function automatic logic [WORD_WIDTH-1:0] magnitude(input logic [WORD_WIDTH-1:0] v);
    logic [WORD_WIDTH-1:0] m;
    if (v[WORD_WIDTH-1]) begin
      m = ~v + ONE;
    end else begin
      m = v;
    end
`ifdef CORDIC_ABS_SAT_EN
    // Negating the most-negative value wraps back to itself; clamp it instead.
    if (v == MOST_NEG) begin
      m = MOST_POS;
    end else begin
      m = m;
    end
`endif
    return m;
  endfunction

  // Next-state: capture on valid, otherwise drop valid and hold the data fields.
  always_comb begin
    valid_d = valid_q;
    abs_d   = abs_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    if (bus.in_valid) begin
      valid_d = 1'b1;
      abs_d   = magnitude(bus.ans);
      neg_d   = bus.ans[WORD_WIDTH-1];
      ovf_d   = (bus.ans == MOST_NEG);
    end else begin
      valid_d = 1'b0;
    end
  end

  // Output registers; reset clears them asynchronously so no stale result escapes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      abs_q   <= {WORD_WIDTH{1'b0}};
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      abs_q   <= abs_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.abs_ans   = abs_q;
  assign bus.neg       = neg_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_cordic_abs.sv
// Directed testbench for cordic_abs at WORD_WIDTH=16 with hand-computed expectations.
module tb_cordic_abs;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   high_cnt;

  cordic_abs_if #(.WORD_WIDTH(16)) bus ();

  cordic_abs #(.WORD_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CORDIC_ABS_SAT_EN
  localparam logic [15:0] MIN_MAG = 16'h7FFF;
`else
  localparam logic [15:0] MIN_MAG = 16'h8000;
`endif

  logic [15:0] v_in  [8];
  logic [15:0] v_mag [8];
  logic        v_neg [8];
  logic        v_ovf [8];

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic v, input logic [15:0] m,
                           input logic n, input logic o);
    check_val({tag, ".valid"}, {15'd0, bus.out_valid}, {15'd0, v});
    check_val({tag, ".abs"},   bus.abs_ans,            m);
    check_val({tag, ".neg"},   {15'd0, bus.neg},       {15'd0, n});
    check_val({tag, ".ovf"},   {15'd0, bus.ovf},       {15'd0, o});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    high_cnt    = 0;
    v_in  = '{16'h0F50, 16'h7FFF, 16'h55A5, 16'hFF50, 16'hFFFF, 16'hAAAA, 16'h0000, 16'h8000};
    v_mag = '{16'h0F50, 16'h7FFF, 16'h55A5, 16'h00B0, 16'h0001, 16'h5556, 16'h0000, MIN_MAG};
    v_neg = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    v_ovf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset held while valid data is offered: outputs must stay cleared.
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.ans      = 16'h8001;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset_hold", 1'b0, 16'h0000, 1'b0, 1'b0);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_val("post_reset.valid", {15'd0, bus.out_valid}, 16'h0000);

    // Individual vectors, each followed by an idle cycle that must hold data.
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.ans      = v_in[i];
      @(posedge clk);
      #1;
      check_all($sformatf("single%0d", i), 1'b1, v_mag[i], v_neg[i], v_ovf[i]);
      bus.in_valid = 1'b0;
      bus.ans      = 16'h1234;
      @(posedge clk);
      #1;
      check_all($sformatf("idle%0d", i), 1'b0, v_mag[i], v_neg[i], v_ovf[i]);
    end

    // Back-to-back stream then five idle cycles.
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.ans      = v_in[i];
      @(posedge clk);
      #1;
      if (bus.out_valid) high_cnt++;
      check_all($sformatf("stream%0d", i), 1'b1, v_mag[i], v_neg[i], v_ovf[i]);
    end
    bus.in_valid = 1'b0;
    bus.ans      = 16'h0F0F;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) high_cnt++;
      check_all($sformatf("drain%0d", i), 1'b0, MIN_MAG, 1'b1, 1'b1);
    end
    check_val("stream_valid_cycles", high_cnt[15:0], 16'd8);

    // Asynchronous reset mid-stream clears outputs before any clock edge.
    bus.in_valid = 1'b1;
    bus.ans      = 16'hFF50;
    @(posedge clk);
    #1;
    check_all("pre_async", 1'b1, 16'h00B0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 1'b0, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("async_hold", 1'b0, 16'h0000, 1'b0, 1'b0);
    rst_n        = 1'b1;
    bus.in_valid = 1'b1;
    bus.ans      = 16'hAAAA;
    @(posedge clk);
    #1;
    check_all("after_reset", 1'b1, 16'h5556, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
